// File: rtl/img_pkg.sv
// Shared definitions for the image line feeder.
// Contents:
//   IMG_WIDTH_DEF / IMG_HEIGHT_DEF  default frame geometry
//   PAD_LINES                       zero lines appended when IMG_FEEDER_PAD_LINES_EN is defined
//   pixel_t                         8-bit greyscale pixel
//   feed_state_t                    feeder FSM states
//   clog2_min1()                    counter width helper (never returns 0)
package img_pkg;

  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;
  localparam int PAD_LINES      = 2;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_CREDIT,
    ST_DRAIN,
    ST_DONE
  } feed_state_t;

  // Bits needed to hold 0..n-1, at least one.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer between the BRAM read stage and the pixel output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_valid/push_data  word arriving from the read stage (caller guarantees room)
//   pix_valid/pix_data    head of the buffer, held stable until taken
//   pix_ready             downstream accept
//   level                 number of stored words (0..2)
module stream_skid_buf
  import img_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  pixel_t     push_data,
  output logic       pix_valid,
  output pixel_t     pix_data,
  input  logic       pix_ready,
  output logic [1:0] level
);

  pixel_t data0;
  pixel_t data1;
  logic   pop;

  assign pix_valid = (level != 2'd0);
  assign pix_data  = data0;
  assign pop       = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 2'd0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      case ({push_valid, pop})
        2'b10: begin
          if (level == 2'd0) data0 <= push_data;
          else               data1 <= push_data;
          level <= level + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          level <= level - 2'd1;
        end
        2'b11: begin
          if (level == 2'd1) begin
            data0 <= push_data;
          end else begin
            data0 <= data1;
            data1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/image_line_feeder.sv
// Raster-order pixel source: reads a greyscale frame from a 1-cycle-latency BRAM
// and streams it over valid/ready, paced by line credits (INIT_LINES at start,
// +1 per i_intr pulse from the downstream processor).
// Optional build macro: IMG_FEEDER_PAD_LINES_EN appends PAD_LINES lines of zero
// pixels after the image, without BRAM reads, each consuming a credit.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                frame start pulse (ignored while busy)
//   o_mem_en, o_mem_addr   BRAM read request
//   i_mem_data             BRAM data, valid the cycle after o_mem_en
//   o_data_valid, o_data   pixel output, i_data_ready downstream accept
//   i_intr                 line-request pulse
//   o_busy, o_done         frame in progress / one-cycle completion pulse
//
// state          | meaning
// ST_IDLE        | waiting for i_start
// ST_STREAM      | issuing reads while buffer room and line credit allow
// ST_WAIT_CREDIT | line finished, no credit left for the next one
// ST_DRAIN       | final read issued, emptying the output buffer
// ST_DONE        | one-cycle o_done pulse, back to idle
module image_line_feeder
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int INIT_LINES = 4,
  parameter int ADDR_W     = 18,
  parameter int CREDIT_W   = 4
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  input  logic              i_intr,
  output logic              o_busy,
  output logic              o_done
);

`ifdef IMG_FEEDER_PAD_LINES_EN
  localparam int TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
`else
  localparam int TOTAL_LINES = IMG_HEIGHT;
`endif
  localparam int PIX_W         = clog2_min1(IMG_WIDTH);
  localparam int LINE_W        = clog2_min1(TOTAL_LINES);
  localparam int CREDIT_MAX_I  = (1 << CREDIT_W) - 1;
  localparam int CREDIT_INIT_I = (INIT_LINES > CREDIT_MAX_I) ? CREDIT_MAX_I : INIT_LINES;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = CREDIT_W'(CREDIT_MAX_I);
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(CREDIT_INIT_I);
  localparam logic [ADDR_W-1:0]   LAST_ADDR   = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  feed_state_t         state, state_next;
  logic [CREDIT_W-1:0] credit, credit_next;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic [ADDR_W-1:0]   addr;
  logic                inflight_v;
  logic [1:0]          buf_level;
  logic [2:0]          occ;
  pixel_t              push_data;
  logic                pop, issue, line_start, last_pix, last_line;
  logic                active, credit_inc, credit_dec, pad_line;

`ifdef IMG_FEEDER_PAD_LINES_EN
  logic inflight_pad;
  assign pad_line  = (line_cnt >= LINE_W'(IMG_HEIGHT));
  assign push_data = inflight_pad ? pixel_t'(0) : i_mem_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) inflight_pad <= 1'b0;
    else       inflight_pad <= issue && pad_line;
  end
`else
  assign pad_line  = 1'b0;
  assign push_data = i_mem_data;
`endif

  stream_skid_buf u_skid (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (inflight_v),
    .push_data  (push_data),
    .pix_valid  (o_data_valid),
    .pix_data   (o_data),
    .pix_ready  (i_data_ready),
    .level      (buf_level)
  );

  assign pop        = o_data_valid && i_data_ready;
  // A word leaving this cycle frees its slot, which keeps 1 pixel/clk with a
  // 2-entry buffer while still never overfilling it.
  assign occ        = 3'(buf_level) + 3'(inflight_v) - 3'(pop);
  assign line_start = (pix_cnt == '0);
  assign last_pix   = (pix_cnt == PIX_W'(IMG_WIDTH - 1));
  assign last_line  = (line_cnt == LINE_W'(TOTAL_LINES - 1));
  assign issue      = (state == ST_STREAM) && (occ < 3'd2) &&
                      (!line_start || (credit != '0));
  assign active     = (state == ST_STREAM) || (state == ST_WAIT_CREDIT) ||
                      (state == ST_DRAIN);
  assign credit_dec = issue && line_start;
  // At saturation an increment is still honoured when it cancels a decrement.
  assign credit_inc = i_intr && active && ((credit != CREDIT_MAX) || credit_dec);
  assign o_mem_addr = addr;

  always_comb begin
    credit_next = credit;
    if ((state == ST_IDLE) && i_start)  credit_next = CREDIT_INIT;
    else if (credit_inc && !credit_dec) credit_next = credit + 1'b1;
    else if (credit_dec && !credit_inc) credit_next = credit - 1'b1;
  end

  always_comb begin
    state_next = state;
    o_mem_en   = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        o_busy   = 1'b1;
        o_mem_en = issue && !pad_line;
        if (issue && last_pix) begin
          if (last_line)               state_next = ST_DRAIN;
          else if (credit_next == '0)  state_next = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        o_busy = 1'b1;
        if (credit != '0) state_next = ST_STREAM;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if ((buf_level == 2'd0) && !inflight_v) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      credit     <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      addr       <= '0;
      inflight_v <= 1'b0;
    end else begin
      state      <= state_next;
      credit     <= credit_next;
      inflight_v <= issue;
      if (issue) begin
        if (last_pix) begin
          pix_cnt  <= '0;
          line_cnt <= last_line ? '0 : line_cnt + 1'b1;
        end else begin
          pix_cnt  <= pix_cnt + 1'b1;
        end
        if (!pad_line) addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_line_feeder.sv
module tb_image_line_feeder;

  localparam int W    = 4;
  localparam int H    = 6;
  localparam int INIT = 4;
  localparam int AW   = 5;
  localparam int CW   = 4;
`ifdef IMG_FEEDER_PAD_LINES_EN
  localparam int LINES = H + 2;
`else
  localparam int LINES = H;
`endif
  localparam int FRAME_PIX = W * LINES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          intr = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          valid;
  logic [7:0]    data;
  logic          busy, done;

  image_line_feeder #(
    .IMG_WIDTH (W), .IMG_HEIGHT (H), .INIT_LINES (INIT), .ADDR_W (AW), .CREDIT_W (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_mem_en     (mem_en),
    .o_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_data_valid (valid),
    .o_data       (data),
    .i_data_ready (ready),
    .i_intr       (intr),
    .o_busy       (busy),
    .o_done       (done)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         late_reads = 0;
  logic [7:0] got[$];
  int         stamp[$];
  bit         after_last = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  // Cycle counter and BRAM model (BRAM[n] = n, one-cycle latency).
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    if (mem_en) mem_data <= 8'(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: image pixels in raster order, then zero pad pixels.
  function automatic logic [7:0] ref_pix(input int k);
    return (k < W * H) ? 8'(k) : 8'h00;
  endfunction

  // Monitor on the falling edge: collects handshakes, checks hold-while-stalled.
  initial forever begin
    @(negedge clk);
    if (prev_stall) begin
      chk("valid_hold", 32'(valid), 32'd1);
      chk("data_hold", 32'(data), 32'(prev_data));
    end
    prev_stall = valid && !ready && !rst;
    prev_data  = data;
    if (valid && ready && !rst) begin
      got.push_back(data);
      stamp.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      chk("busy_low_with_done", 32'(busy), 32'd0);
    end
    if (start) after_last = 1'b0;
    else begin
      if (after_last && mem_en) late_reads++;
      if (mem_en && mem_addr == AW'(W * H - 1)) after_last = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    got.delete();
    stamp.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_intr();
    intr = 1'b1;
    tick();
    intr = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("pixel_count_reached", 32'(got.size()), 32'(n));
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int ready_pct, input int intr_pct);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (rnd) begin
        ready = ($urandom_range(99) < ready_pct);
        intr  = ($urandom_range(99) < intr_pct);
      end
      tick();
      k++;
    end
    intr  = 1'b0;
    ready = 1'b1;
    chk("frame_done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_size"}, 32'(got.size()), 32'(FRAME_PIX));
    for (int i = 0; i < FRAME_PIX && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(ref_pix(i)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int rp, ip;

    // Reset values
    ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Case 1: line requests in IDLE are ignored; 4 initial lines at 1 pixel/clk
    repeat (3) pulse_intr();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_cycle1", 32'(valid), 32'd0);
    tick();
    chk("valid_cycle2", 32'(valid), 32'd0);
    tick();
    chk("valid_cycle3", 32'(valid), 32'd1);
    chk("first_pixel", 32'(data), 32'd0);
    wait_pix(INIT * W, 100);
    repeat (20) tick();
    chk("stall_count", 32'(got.size()), 32'(INIT * W));
    chk("stall_valid", 32'(valid), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    if (stamp.size() >= INIT * W)
      chk("throughput_init_lines", 32'(stamp[INIT*W-1] - stamp[0]), 32'(INIT * W - 1));
    pulse_start();
    repeat (5) tick();
    chk("start_while_busy_ignored", 32'(got.size()), 32'(INIT * W));

    // Case 2: one request per remaining line completes the frame
    for (int l = INIT; l < LINES; l++) begin
      pulse_intr();
      wait_pix(W * (l + 1), 100);
    end
    wait_done(200, 1'b0, 100, 0);
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("single_done_pulse", 32'(done_cnt), 32'd1);
    check_frame("frame_directed");

    // Case 3: alternating ready during line 0
    do_reset();
    ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 60 && got.size() < W; k++) begin
      ready = ~ready;
      tick();
    end
    ready = 1'b1;
    chk("toggle_count", 32'(got.size() >= W), 32'd1);
    for (int i = 0; i < W && i < got.size(); i++)
      chk("toggle_pixel", 32'(got[i]), 32'(i));

    // Case 4: request coinciding with the first read of a line at credit 1
    do_reset();
    ready = 1'b1;
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (mem_en && mem_addr == AW'((INIT - 1) * W)) hit = 1'b1;
    end
    chk("saw_credit1_line_read", 32'(hit), 32'd1);
    intr = 1'b1;
    tick();
    intr = 1'b0;
    wait_pix((INIT + 1) * W, 100);
    repeat (20) tick();
    chk("net_zero_credit_count", 32'(got.size()), 32'((INIT + 1) * W));
    if (stamp.size() >= (INIT + 1) * W)
      chk("no_bubble", 32'(stamp[(INIT+1)*W-1] - stamp[0]), 32'((INIT + 1) * W - 1));

    // Case 5: reset mid-frame, then restart from pixel 0 with fresh credits
    do_reset();
    ready = 1'b1;
    pulse_start();
    wait_pix(10, 100);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    got.delete();
    stamp.delete();
    tick();
    pulse_start();
    wait_pix(INIT * W, 100);
    repeat (20) tick();
    chk("restart_count", 32'(got.size()), 32'(INIT * W));
    for (int i = 0; i < INIT * W && i < got.size(); i++)
      chk("restart_pixel", 32'(got[i]), 32'(i));

    // Randomized frames: random backpressure and line requests vs reference
    for (int f = 0; f < 4; f++) begin
      do_reset();
      rp = $urandom_range(100, 20);
      ip = $urandom_range(25, 5);
      ready = ($urandom_range(1) == 1);
      pulse_start();
      wait_done(4000, 1'b1, rp, ip);
      repeat (3) tick();
      check_frame("frame_random");
    end

    chk("reads_after_last_address", 32'(late_reads), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_line_feeder.md
Name: image_line_feeder

Overview:
- Stream source that feeds the image processing pipeline's slave pixel input.
- Reads an 8-bit greyscale frame from a single-port BRAM (1-cycle read latency) in raster order.
- Drives an AXI-stream-style valid/ready master interface.
- Paces output by line credits: INIT_LINES lines at start, then one more line per line-request interrupt from the downstream processor.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- INIT_LINES, 4, line credits granted at frame start.
- ADDR_W, 18, BRAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- CREDIT_W, 4, credit counter width; saturates at 2^CREDIT_W-1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle pulse; begins a frame when idle.
- o_mem_en  out  1  BRAM read enable.
- o_mem_addr  out  ADDR_W  BRAM read address.
- i_mem_data  in  8  BRAM read data, valid the cycle after o_mem_en.
- o_data_valid  out  1  pixel valid to downstream.
- o_data  out  8  pixel data.
- i_data_ready  in  1  downstream ready.
- i_intr  in  1  one-cycle line-request pulse from downstream.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset values: o_mem_en=0, o_mem_addr=0, o_data_valid=0, o_data=0, o_busy=0, o_done=0. Credits, pixel, line and address counters are cleared.
- Reset mid-frame: all of the above take effect next cycle. o_data_valid drops even if not accepted. No pending credit survives.
- FSM states: IDLE, STREAM, WAIT_CREDIT, DRAIN, DONE.
  - IDLE -> STREAM on i_start. Credits load INIT_LINES and o_busy sets.
  - STREAM: issue reads while credit>0.
  - STREAM -> WAIT_CREDIT when a line's last read is issued and credit becomes 0.
  - WAIT_CREDIT -> STREAM when credit>0.
  - STREAM -> DRAIN after the final frame read is issued.
  - DRAIN -> DONE when the output buffer is empty and the last pixel has handshaken.
  - DONE: pulse o_done, clear o_busy, go to IDLE.
- Credit accounting:
  - Credit decrements when the first read of a line is issued.
  - i_intr increments credit in any state except IDLE/DONE; in IDLE/DONE it is ignored.
  - Simultaneous i_intr and decrement gives net 0.
  - At saturation, increments are dropped.
- i_start while busy is ignored.
- Read issue: o_mem_en=1 only when (buffered + in-flight) < 2. This guarantees no overflow of the 2-entry output buffer. Address increments by 1 per issued read and wraps to 0 at frame end.
- Output handshake:
  - A pixel transfers on o_data_valid && i_data_ready.
  - Once asserted, o_data_valid holds and o_data stays stable until transfer.
  - With i_data_ready held high and credit available, throughput is 1 pixel/clk.
  - Latency from i_start to first o_data_valid is 3 cycles: start, read, buffer load.
- Backpressure: i_data_ready low stalls reads within 1 cycle. No pixel is lost or duplicated.
- Line boundary: the pixel counter wraps at IMG_WIDTH-1 and increments the line counter. The frame ends after line IMG_HEIGHT-1, or after the pad lines if enabled.

Optional Feature:
- Macro IMG_FEEDER_PAD_LINES_EN.
- When defined: after the last image line, the block emits 2 additional lines of zero pixels without BRAM reads (o_mem_en stays low). These lines consume credits like normal lines. Downstream 3x3 convolution then produces IMG_HEIGHT output lines. The frame is IMG_WIDTH*(IMG_HEIGHT+2) pixels.
- When undefined: the frame is exactly IMG_WIDTH*IMG_HEIGHT pixels. No pad logic is present.

Decomposition:
- Shared package img_pkg:
  - default IMG_WIDTH/IMG_HEIGHT;
  - pixel typedef (8-bit);
  - FSM state enum;
  - PAD_LINES=2 constant.
- One sub-module, stream_skid_buf: 2-entry valid/ready buffer absorbing the 1-cycle BRAM latency.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=6, INIT_LINES=4, BRAM[n]=n):
1. i_start, ready always high, no i_intr -> pixels 0..15 at 1/clk, first valid 3 cycles after start; then stalls in WAIT_CREDIT with valid low.
2. Continue case 1 with i_intr pulses after pixel 15 and after pixel 19 -> pixels 16..23 emitted; o_done pulses once after pixel 23; o_busy falls with it.
3. Ready toggling 1-0-1-0 during line 0 -> sequence exactly 0,1,2,3; o_data stable while valid && !ready.
4. i_intr on the same cycle as a line's first read, credit=1 -> credit stays 1 and streaming continues without a WAIT_CREDIT bubble.
5. i_rst asserted at pixel 9 -> next cycle valid=0, busy=0; a new i_start restarts from pixel 0 with 4 credits.
6. With IMG_FEEDER_PAD_LINES_EN and 4 extra i_intr pulses -> 32 pixels total; last 8 are 0; o_mem_en never high after address 23.
